// File: rtl/lcd_scanout.sv
// LCD raster generator that pops one show-ahead FIFO word per active pixel; syncs, DE and data are registered, so they appear 1 cycle after the counter state.
// The FIFO pop is combinational and is never stalled. An empty FIFO during active video drives UNDERFLOW_COLOR and sets a sticky flag.
module lcd_scanout #(
    parameter int PIXEL_WIDTH = 16,
    parameter int H_ACTIVE    = 480,
    parameter int H_FP        = 8,
    parameter int H_SYNC      = 4,
    parameter int H_BP        = 43,
    parameter int V_ACTIVE    = 200,
    parameter int V_FP        = 4,
    parameter int V_SYNC      = 4,
    parameter int V_BP        = 12,
    parameter logic [PIXEL_WIDTH-1:0] UNDERFLOW_COLOR = '0
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_First_Data_Ready,
    input  logic                   i_FIFO_Empty,
    input  logic [PIXEL_WIDTH-1:0] i_FIFO_Data,
    output logic                   o_FIFO_Rd,
    output logic                   o_LCD_HSYNC,
    output logic                   o_LCD_VSYNC,
    output logic                   o_LCD_DE,
    output logic [PIXEL_WIDTH-1:0] o_LCD_Data,
    output logic                   o_Frame_Start,
    output logic                   o_Underflow
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_LO = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_HI = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_LO = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_HI = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

    typedef enum logic {ST_WAIT, ST_RUN} state_t;

    state_t                 state_q, state_d;
    logic [9:0]             h_cnt_q, h_cnt_d;
    logic [9:0]             v_cnt_q, v_cnt_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   de_q, de_d;
    logic [PIXEL_WIDTH-1:0] data_q, data_d;
    logic                   frame_start_q, frame_start_d;
    logic                   underflow_q, underflow_d;
    logic                   run;
    logic                   active;

    assign run       = (state_q == ST_RUN);
    assign active    = run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign o_FIFO_Rd = active && !i_FIFO_Empty;

    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        hsync_d       = 1'b1;
        vsync_d       = 1'b1;
        de_d          = active;
        data_d        = '0;
        frame_start_d = 1'b0;
        underflow_d   = underflow_q | (active & i_FIFO_Empty);

        if (state_q == ST_WAIT) begin
            // Counters stay parked at (0,0) so RUN begins at the first pixel.
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (i_First_Data_Ready) begin
                state_d = ST_RUN;
            end
        end else begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            hsync_d       = !((h_cnt_q >= H_SYNC_LO) && (h_cnt_q < H_SYNC_HI));
            vsync_d       = !((v_cnt_q >= V_SYNC_LO) && (v_cnt_q < V_SYNC_HI));
            frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        end

        // Underflow drops the pixel rather than stalling, so timing never slips.
        if (o_FIFO_Rd) begin
            data_d = i_FIFO_Data;
        end else if (active) begin
            data_d = UNDERFLOW_COLOR;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q       <= ST_WAIT;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            data_q        <= '0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            data_q        <= data_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign o_LCD_HSYNC   = hsync_q;
    assign o_LCD_VSYNC   = vsync_q;
    assign o_LCD_DE      = de_q;
    assign o_LCD_Data    = data_q;
    assign o_Frame_Start = frame_start_q;
    assign o_Underflow   = underflow_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: raster position is derived from elapsed RUN cycles by division/modulo, and the FIFO is modelled as a counter.
module tb_lcd_scanout;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1, HT = HA + HF + HS + HB;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1, VT = VA + VF + VS + VB;
    localparam logic [15:0] UC = 16'hF00F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy_i, emp_i;
    logic [15:0] fdat_i;
    logic        rd_o, hs_o, vs_o, de_o, fs_o, uf_o;
    logic [15:0] data_o;

    lcd_scanout #(
        .PIXEL_WIDTH(16), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .UNDERFLOW_COLOR(UC)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_First_Data_Ready(rdy_i),
        .i_FIFO_Empty(emp_i), .i_FIFO_Data(fdat_i), .o_FIFO_Rd(rd_o),
        .o_LCD_HSYNC(hs_o), .o_LCD_VSYNC(vs_o), .o_LCD_DE(de_o),
        .o_LCD_Data(data_o), .o_Frame_Start(fs_o), .o_Underflow(uf_o)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;

    // reference model state
    bit          running;
    int          t;
    int          fifo_val;
    logic        e_de, e_hs, e_vs, e_fs, e_uf;
    logic [15:0] e_data;

    // last sampled outputs and statistics
    logic        s_rd, s_de, s_hs, s_vs, s_fs, s_uf;
    logic [15:0] s_data;
    int n_rd, n_de, vs_run, vs_max;
    int fs_cyc[$];
    int fs_dat[$];

    typedef struct {
        logic        rdy;
        logic        emp;
        logic        rd;
        logic        de;
        logic [15:0] data;
        logic        hs;
        logic        vs;
        logic        fs;
    } vec_t;
    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        running  = 0;
        t        = 0;
        fifo_val = 1;
        e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_uf = 0; e_data = '0;
    endtask

    task automatic do_reset();
        rst_n = 0; rdy_i = 0; emp_i = 0; fdat_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic clear_stats();
        n_rd = 0; n_de = 0; vs_run = 0; vs_max = 0;
        fs_cyc.delete();
        fs_dat.delete();
    endtask

    // One clock: drive inputs just after posedge, sample/check at negedge, advance model.
    task automatic cycle(input logic rdy, input logic emp);
        int   h, v;
        logic act, erd;
        rdy_i  = rdy;
        emp_i  = emp;
        fdat_i = emp ? 16'hDEAD : 16'(fifo_val);
        @(negedge clk);
        h   = t % HT;
        v   = (t / HT) % VT;
        act = running && (h < HA) && (v < VA);
        erd = act && !emp;
        s_rd = rd_o; s_de = de_o; s_hs = hs_o; s_vs = vs_o;
        s_fs = fs_o; s_uf = uf_o; s_data = data_o;
        chk("rd", 32'(s_rd), 32'(erd));
        chk("de", 32'(s_de), 32'(e_de));
        chk("data", 32'(s_data), 32'(e_data));
        chk("hsync", 32'(s_hs), 32'(e_hs));
        chk("vsync", 32'(s_vs), 32'(e_vs));
        chk("frame_start", 32'(s_fs), 32'(e_fs));
        chk("underflow", 32'(s_uf), 32'(e_uf));
        if (s_rd) n_rd++;
        if (s_de) n_de++;
        if (!s_vs) begin
            vs_run++;
            if (vs_run > vs_max) vs_max = vs_run;
        end else begin
            vs_run = 0;
        end
        if (s_fs) begin
            fs_cyc.push_back(cyc);
            fs_dat.push_back(int'(s_data));
        end
        e_de   = act;
        e_data = erd ? 16'(fifo_val) : (act ? UC : 16'h0);
        e_hs   = !(running && h >= HA + HF && h < HA + HF + HS);
        e_vs   = !(running && v >= VA + VF && v < VA + VF + VS);
        e_fs   = running && h == 0 && v == 0;
        e_uf   = e_uf | (act && emp);
        if (erd) fifo_val++;
        if (running) t++;
        else if (rdy) begin
            running = 1;
            t = 0;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rdy emp  rd de data hs vs fs
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'd5, 1'b1, 1'b1, 1'b0};

        // Idle in WAIT with a primed FIFO
        do_reset();
        clear_stats();
        repeat (50) cycle(1'b0, 1'b0);
        chk("wait_no_pop", 32'(n_rd), 32'd0);
        chk("wait_no_de", 32'(n_de), 32'd0);

        // Start, first line (table), then ready dropped for the rest of the frame
        clear_stats();
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].rdy, tbl[i].emp);
            chk($sformatf("tbl_rd[%0d]", i), 32'(s_rd), 32'(tbl[i].rd));
            chk($sformatf("tbl_de[%0d]", i), 32'(s_de), 32'(tbl[i].de));
            chk($sformatf("tbl_data[%0d]", i), 32'(s_data), 32'(tbl[i].data));
            chk($sformatf("tbl_hs[%0d]", i), 32'(s_hs), 32'(tbl[i].hs));
            chk($sformatf("tbl_vs[%0d]", i), 32'(s_vs), 32'(tbl[i].vs));
            chk($sformatf("tbl_fs[%0d]", i), 32'(s_fs), 32'(tbl[i].fs));
        end
        repeat (38) cycle(1'b0, 1'b0);
        chk("frame_pops", 32'(n_rd), 32'd12);
        chk("frame_de", 32'(n_de), 32'd12);
        repeat (7) cycle(1'b0, 1'b0);
        chk("vsync_low_len", 32'(vs_max), 32'd8);
        chk("fs_count", 32'(fs_cyc.size()), 32'd2);
        if (fs_cyc.size() >= 2) begin
            chk("fs_period", 32'(fs_cyc[1] - fs_cyc[0]), 32'd48);
            chk("frame2_first_data", 32'(fs_dat[1]), 32'd13);
        end

        // Underflow on the third active pixel of line 0
        do_reset();
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        chk("uf_no_pop", 32'(s_rd), 32'd0);
        cycle(1'b0, 1'b0);
        chk("uf_color", 32'(s_data), 32'(UC));
        chk("uf_de", 32'(s_de), 32'd1);
        chk("uf_flag", 32'(s_uf), 32'd1);
        cycle(1'b0, 1'b0);
        chk("uf_next_pixel", 32'(s_data), 32'd3);
        repeat (110) cycle(1'b0, 1'b0);
        chk("uf_sticky", 32'(s_uf), 32'd1);

        // Asynchronous reset mid-line 1
        do_reset();
        cycle(1'b1, 1'b0);
        repeat (11) cycle(1'b1, 1'b0);
        #2 rst_n = 0;
        #1;
        chk("arst_rd", 32'(rd_o), 32'd0);
        chk("arst_de", 32'(de_o), 32'd0);
        chk("arst_data", 32'(data_o), 32'd0);
        chk("arst_hs", 32'(hs_o), 32'd1);
        chk("arst_vs", 32'(vs_o), 32'd1);
        chk("arst_fs", 32'(fs_o), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        chk("restart_fs", 32'(s_fs), 32'd1);
        chk("restart_data", 32'(s_data), 32'd1);

        // Randomized ready/empty against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle((i > 20) ? 1'b1 : 1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
